// File: rtl/vliw_bundle_fetch_pkg.sv
// Shared definitions for the VLIW bundle store/fetch slice: FSM encodings,
// default geometry and slot-placement helper.
package vliw_bundle_fetch_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    localparam int unsigned NSLOT_DEF  = 10;
    localparam int unsigned SLOT_W_DEF = 32;

    localparam logic [SLOT_W_DEF-1:0] NOP_SLOT = '0;

    // Slot 0 occupies the MSBs of a bundle; returns the LSB offset of slot k.
    function automatic int unsigned slot_lsb(input int unsigned nslot,
                                             input int unsigned slot_w,
                                             input int unsigned k);
        return (nslot - 1 - k) * slot_w;
    endfunction

endpackage

// File: rtl/vliw_bundle_fetch_if.sv
// Load-port and fetch-port signal bundle for vliw_bundle_fetch.
interface vliw_bundle_fetch_if #(
    parameter int unsigned NSLOT  = 10,
    parameter int unsigned SLOT_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned PC_W   = 32
);
    localparam int unsigned BW = NSLOT * SLOT_W;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              ld_start;
    logic [AW-1:0]     ld_base;
    logic              ld_valid;
    logic              ld_ready;
    logic [SLOT_W-1:0] ld_data;
    logic              ld_end;
    logic              run;
    logic [PC_W-1:0]   run_pc;
    logic              br_valid;
    logic [PC_W-1:0]   br_target;
    logic              f_valid;
    logic              f_ready;
    logic [BW-1:0]     f_bundle;
    logic [PC_W-1:0]   f_pc;
    logic [NSLOT-1:0]  nop_mask;
    logic              halted;

    modport master (
        output ld_start, ld_base, ld_valid, ld_data, ld_end,
        output run, run_pc, br_valid, br_target, f_ready,
        input  ld_ready, f_valid, f_bundle, f_pc, nop_mask, halted
    );

    modport slave (
        input  ld_start, ld_base, ld_valid, ld_data, ld_end,
        input  run, run_pc, br_valid, br_target, f_ready,
        output ld_ready, f_valid, f_bundle, f_pc, nop_mask, halted
    );

endinterface

// File: rtl/vliw_bundle_fetch_bundle_assembler.sv
// Packs incoming slot words into a bundle and emits a write strobe when the
// bundle fills or the load is closed with a partial bundle (zero-filled).
module bundle_assembler
    import vliw_bundle_fetch_pkg::*;
#(
    parameter int unsigned NSLOT  = 10,
    parameter int unsigned SLOT_W = 32,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned BW = NSLOT * SLOT_W,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW-1:0]     base,
    input  logic              active,
    input  logic              word_vld,
    input  logic [SLOT_W-1:0] word,
    input  logic              close,
    output logic              wr_en,
    output logic [AW-1:0]     wr_idx,
    output logic [BW-1:0]     wr_bundle
);

    logic [BW-1:0] asm_q;
    logic [BW-1:0] merged;
    logic [CW-1:0] cnt;
    logic [AW-1:0] wptr;
    logic          last;

    // The word accepted this cycle is merged before the write decision, so a
    // word coinciding with close is part of the stored bundle.
    always_comb begin
        merged = asm_q;
        if (word_vld) begin
            merged[slot_lsb(NSLOT, SLOT_W, 32'(cnt)) +: SLOT_W] = word;
        end
        last      = word_vld && (cnt == CW'(NSLOT - 1));
        wr_en     = active && (last || (close && (word_vld || (cnt != '0))));
        wr_idx    = wptr;
        wr_bundle = merged;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q <= '0;
            cnt   <= '0;
            wptr  <= '0;
        end else if (start) begin
            asm_q <= '0;
            cnt   <= '0;
            wptr  <= base;
        end else if (active) begin
            if (wr_en) begin
                asm_q <= '0;
                cnt   <= '0;
                wptr  <= wptr + 1'b1;
            end else if (word_vld) begin
                asm_q <= merged;
                cnt   <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vliw_bundle_fetch.sv
// VLIW bundle store with word-stream load port and PC-driven fetch stage
// (valid/ready output, branch redirect, halt on an all-NOP bundle).
module vliw_bundle_fetch
    import vliw_bundle_fetch_pkg::*;
#(
    parameter int unsigned NSLOT   = 10,
    parameter int unsigned SLOT_W  = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned PC_STEP = 4
) (
    input logic          clk,
    input logic          rst_n,
    vliw_bundle_fetch_if.slave bus
);

    localparam int unsigned BW = NSLOT * SLOT_W;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SW = (PC_STEP > 1) ? $clog2(PC_STEP) : 0;

    logic [1:0]       state;
    logic [PC_W-1:0]  pc;
    logic [BW-1:0]    mem [DEPTH];

    logic             fv_q;
    logic [BW-1:0]    fb_q;
    logic [PC_W-1:0]  fpc_q;
    logic [NSLOT-1:0] mask_q;
    logic             halt_q;

    logic             in_load;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [BW-1:0]    wr_bundle;
    logic [AW-1:0]    rd_idx;
    logic [BW-1:0]    rd_bundle;
    logic [NSLOT-1:0] rd_mask;
    logic             rd_zero;

    assign in_load = (state == ST_LOAD);

    bundle_assembler #(
        .NSLOT  (NSLOT),
        .SLOT_W (SLOT_W),
        .DEPTH  (DEPTH)
    ) u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     ((state == ST_IDLE) && bus.ld_start),
        .base      (bus.ld_base),
        .active    (in_load),
        .word_vld  (in_load && bus.ld_valid),
        .word      (bus.ld_data),
        .close     (in_load && bus.ld_end),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_bundle (wr_bundle)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_bundle;
        end
    end

    assign rd_idx    = pc[SW +: AW];
    assign rd_bundle = mem[rd_idx];
    assign rd_zero   = (rd_bundle == '0);

    always_comb begin
        rd_mask = '0;
        for (int unsigned k = 0; k < NSLOT; k++) begin
            rd_mask[k] = (rd_bundle[slot_lsb(NSLOT, SLOT_W, k) +: SLOT_W] == '0);
        end
    end

    // Priority in RUN: run drop, then branch flush, then advance/halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            pc     <= '0;
            fv_q   <= 1'b0;
            fb_q   <= '0;
            fpc_q  <= '0;
            mask_q <= '0;
            halt_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.ld_start) begin
                        state <= ST_LOAD;
                    end else if (bus.run) begin
                        state <= ST_RUN;
                        pc    <= bus.run_pc;
                    end
                end
                ST_LOAD: begin
                    if (bus.ld_end) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!bus.run) begin
                        state <= ST_IDLE;
                        fv_q  <= 1'b0;
                    end else if (bus.br_valid) begin
                        pc   <= bus.br_target;
                        fv_q <= 1'b0;
                    end else if (!fv_q || bus.f_ready) begin
                        if (rd_zero) begin
                            fv_q   <= 1'b0;
                            halt_q <= 1'b1;
                            state  <= ST_HALT;
                        end else begin
                            fv_q   <= 1'b1;
                            fb_q   <= rd_bundle;
                            fpc_q  <= pc;
                            mask_q <= rd_mask;
                            pc     <= pc + PC_W'(PC_STEP);
                        end
                    end
                end
                ST_HALT: begin
                    if (!bus.run) begin
                        state  <= ST_IDLE;
                        halt_q <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ld_ready = in_load;
    assign bus.f_valid  = fv_q;
    assign bus.f_bundle = fb_q;
    assign bus.f_pc     = fpc_q;
    assign bus.nop_mask = mask_q;
    assign bus.halted   = halt_q;

endmodule

// File: tb/tb_vliw_bundle_fetch.sv
// Directed + randomized bench for vliw_bundle_fetch against a slot-array model.
module tb_vliw_bundle_fetch;

    localparam int NSLOT = 10;
    localparam int BW    = 320;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        ld_start = 1'b0, ld_valid = 1'b0, ld_end = 1'b0;
    logic        run = 1'b0, br_valid = 1'b0, f_ready = 1'b0;
    logic [3:0]  ld_base = '0;
    logic [31:0] ld_data = '0, run_pc = '0, br_target = '0;

    logic           ld_ready, f_valid, halted;
    logic [BW-1:0]  f_bundle;
    logic [31:0]    f_pc;
    logic [NSLOT-1:0] nop_mask;

    int checks = 0;
    int failures = 0;

    logic [31:0] ref_mem [16][NSLOT];
    int          dep = 16;
    logic [31:0] wq [$];

    always #5 clk = ~clk;

    vliw_bundle_fetch_if #(.NSLOT(10), .SLOT_W(32), .DEPTH(16), .PC_W(32)) bi ();
    vliw_bundle_fetch_if #(.NSLOT(10), .SLOT_W(32), .DEPTH(4),  .PC_W(32)) b4 ();

    vliw_bundle_fetch #(.NSLOT(10), .SLOT_W(32), .DEPTH(16), .PC_W(32), .PC_STEP(4))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bi));
    vliw_bundle_fetch #(.NSLOT(10), .SLOT_W(32), .DEPTH(4), .PC_W(32), .PC_STEP(4))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(b4));

    assign bi.ld_start  = ld_start & ~sel;
    assign bi.ld_base   = ld_base;
    assign bi.ld_valid  = ld_valid & ~sel;
    assign bi.ld_data   = ld_data;
    assign bi.ld_end    = ld_end & ~sel;
    assign bi.run       = run & ~sel;
    assign bi.run_pc    = run_pc;
    assign bi.br_valid  = br_valid & ~sel;
    assign bi.br_target = br_target;
    assign bi.f_ready   = f_ready;

    assign b4.ld_start  = ld_start & sel;
    assign b4.ld_base   = ld_base[1:0];
    assign b4.ld_valid  = ld_valid & sel;
    assign b4.ld_data   = ld_data;
    assign b4.ld_end    = ld_end & sel;
    assign b4.run       = run & sel;
    assign b4.run_pc    = run_pc;
    assign b4.br_valid  = br_valid & sel;
    assign b4.br_target = br_target;
    assign b4.f_ready   = f_ready;

    assign ld_ready = sel ? b4.ld_ready : bi.ld_ready;
    assign f_valid  = sel ? b4.f_valid  : bi.f_valid;
    assign f_bundle = sel ? b4.f_bundle : bi.f_bundle;
    assign f_pc     = sel ? b4.f_pc     : bi.f_pc;
    assign nop_mask = sel ? b4.nop_mask : bi.nop_mask;
    assign halted   = sel ? b4.halted   : bi.halted;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int b = 0; b < 16; b++)
            for (int k = 0; k < NSLOT; k++) ref_mem[b][k] = '0;
    endtask

    function automatic logic [BW-1:0] exp_bundle(input logic [31:0] pc);
        logic [BW-1:0] b;
        int idx;
        idx = int'((pc >> 2) % 32'(dep));
        b = '0;
        for (int k = 0; k < NSLOT; k++) b[BW-1-32*k -: 32] = ref_mem[idx][k];
        return b;
    endfunction

    function automatic logic [NSLOT-1:0] exp_mask(input logic [31:0] pc);
        logic [NSLOT-1:0] m;
        int idx;
        idx = int'((pc >> 2) % 32'(dep));
        for (int k = 0; k < NSLOT; k++) m[k] = (ref_mem[idx][k] == 32'd0);
        return m;
    endfunction

    function automatic int nz_run(input logic [31:0] pc0);
        logic [31:0] p;
        int n;
        bit stop;
        p = pc0; n = 0; stop = 0;
        for (int i = 0; i < dep; i++) begin
            if (!stop && exp_bundle(p) != '0) begin n++; p += 4; end
            else stop = 1;
        end
        return n;
    endfunction

    // Streams wq[0..n-1] starting at bundle `base`; close either with the last word or after it.
    task automatic load(input int base, input int n, input bit end_last, input bit gaps);
        int b, s;
        ld_base = 4'(base); ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            b = (base + i / NSLOT) % dep;
            s = i % NSLOT;
            if (gaps && $urandom_range(0, 2) == 0) begin ld_valid = 1'b0; tick(); end
            if (s == 0) for (int k = 0; k < NSLOT; k++) ref_mem[b][k] = '0;
            ref_mem[b][s] = wq[i];
            ld_valid = 1'b1; ld_data = wq[i]; ld_end = end_last && (i == n - 1);
            chk("ld_ready_load", ld_ready, 1'b1);
            tick();
        end
        ld_valid = 1'b0; ld_end = 1'b0;
        if (!end_last) begin ld_end = 1'b1; tick(); ld_end = 1'b0; end
        chk("ld_ready_idle", ld_ready, 1'b0);
    endtask

    task automatic fetch_check(input logic [31:0] pc0, input int max_present,
                               input bit expect_halt, input bit rand_ready);
        logic [31:0] epc;
        int presented, cyc, exp_n;
        logic fr;
        epc = pc0; presented = 0; cyc = 0;
        exp_n = nz_run(pc0);
        run_pc = pc0; run = 1'b1; f_ready = 1'b1;
        tick();
        while (!halted && presented < max_present && cyc < 400) begin
            fr = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            f_ready = fr;
            if (f_valid) begin
                chk("f_pc", f_pc, epc);
                chk("f_bundle", f_bundle, exp_bundle(epc));
                chk("nop_mask", nop_mask, exp_mask(epc));
                if (fr) begin presented++; epc += 4; end
            end
            tick();
            cyc++;
        end
        chk("fetch_budget", cyc < 400, 1'b1);
        if (expect_halt) begin
            chk("halt_flag", halted, 1'b1);
            chk("halt_fvalid", f_valid, 1'b0);
            chk("halt_count", presented, exp_n);
        end
        run = 1'b0; f_ready = 1'b1;
        tick();
        chk("stop_fvalid", f_valid, 1'b0);
        chk("stop_halted", halted, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        #3;
        chk("rst_ld_ready", ld_ready, 1'b0);
        chk("rst_f_valid", f_valid, 1'b0);
        chk("rst_f_bundle", f_bundle, '0);
        chk("rst_f_pc", f_pc, '0);
        chk("rst_nop_mask", nop_mask, '0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_b_f_valid", b4.f_valid, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        tick();

        // 1: three bundles, straight-line fetch then halt
        wq.delete();
        for (int i = 0; i < 30; i++) wq.push_back($urandom | 32'h1);
        wq[7] = 32'h9140_01C3; wq[17] = 32'h90C0_021F; wq[23] = 32'h29CA_3000;
        load(0, 30, 1'b1, 1'b0);
        run_pc = 0; run = 1'b1; f_ready = 1'b1;
        tick(); tick();
        chk("t1_v0", f_valid, 1'b1);
        chk("t1_pc0", f_pc, 32'd0);
        chk("t1_b0", f_bundle, exp_bundle(0));
        chk("t1_slot7_b0", f_bundle[95 -: 32], 32'h9140_01C3);
        tick();
        chk("t1_pc4", f_pc, 32'd4);
        chk("t1_slot7_b1", f_bundle[95 -: 32], 32'h90C0_021F);
        tick();
        chk("t1_pc8", f_pc, 32'd8);
        chk("t1_slot3_b2", f_bundle[223 -: 32], 32'h29CA_3000);
        chk("t1_b2", f_bundle, exp_bundle(8));
        tick();
        chk("t1_halted", halted, 1'b1);
        chk("t1_halt_fv", f_valid, 1'b0);

        // 2: stall at pc 4 then release
        run = 1'b0; tick();
        run = 1'b1; tick(); tick(); tick();
        chk("t2_pc4", f_pc, 32'd4);
        f_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_stall_v", f_valid, 1'b1);
            chk("t2_stall_pc", f_pc, 32'd4);
            chk("t2_stall_b", f_bundle, exp_bundle(4));
        end
        f_ready = 1'b1; tick();
        chk("t2_rel_pc", f_pc, 32'd8);
        chk("t2_rel_b", f_bundle, exp_bundle(8));
        tick();
        chk("t2_halted", halted, 1'b1);
        run = 1'b0; tick();

        // 3: branch to 0 while pc 4 presented
        run = 1'b1; tick(); tick(); tick();
        chk("t3_pc4", f_pc, 32'd4);
        br_valid = 1'b1; br_target = 32'd0;
        tick();
        br_valid = 1'b0;
        chk("t3_flush", f_valid, 1'b0);
        tick();
        chk("t3_tgt_v", f_valid, 1'b1);
        chk("t3_tgt_pc", f_pc, 32'd0);
        chk("t3_tgt_b", f_bundle, exp_bundle(0));
        run = 1'b0; tick();
        chk("t3_stop_fv", f_valid, 1'b0);

        // 4: partial bundle zero-filled
        wq.delete();
        for (int i = 0; i < 3; i++) wq.push_back($urandom | 32'h100);
        load(5, 3, 1'b0, 1'b0);
        run_pc = 32'd20; run = 1'b1; f_ready = 1'b1;
        tick(); tick();
        chk("t4_pc", f_pc, 32'd20);
        chk("t4_bundle", f_bundle, exp_bundle(20));
        chk("t4_mask", nop_mask, 10'h3F8);
        tick();
        chk("t4_halt", halted, 1'b1);
        run = 1'b0; tick();

        // 6: reset in the middle of a load
        wq.delete();
        for (int i = 0; i < 4; i++) wq.push_back($urandom | 32'h1);
        ld_base = 4'd0; ld_start = 1'b1; tick(); ld_start = 1'b0;
        for (int i = 0; i < 4; i++) begin ld_valid = 1'b1; ld_data = wq[i]; tick(); end
        ld_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_ld_ready", ld_ready, 1'b0);
        chk("t6_f_valid", f_valid, 1'b0);
        chk("t6_f_bundle", f_bundle, '0);
        chk("t6_f_pc", f_pc, '0);
        chk("t6_halted", halted, 1'b0);
        clear_model();
        @(negedge clk); rst_n = 1'b1;
        tick();
        fetch_check(32'd0, 1000, 1'b1, 1'b0);

        // randomized loads and stalled fetch runs
        for (int it = 0; it < 4; it++) begin
            int base, n;
            base = $urandom_range(0, 15);
            n = $urandom_range(1, 30);
            wq.delete();
            for (int i = 0; i < n; i++)
                wq.push_back(($urandom_range(0, 7) == 0) ? 32'd0 : $urandom);
            load(base, n, 1'($urandom_range(0, 1)), 1'b1);
            fetch_check(32'(base * 4 + $urandom_range(0, 3)), 1000, 1'b1, 1'b1);
        end

        // 5: DEPTH=4 store, wrap from index 3
        sel = 1'b1; dep = 4;
        clear_model();
        wq.delete();
        for (int i = 0; i < 8 * NSLOT; i++) wq.push_back($urandom | 32'h1);
        load(3, 8 * NSLOT, 1'b1, 1'b0);
        fetch_check(32'd12, 6, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
